// File: rtl/myrisc16_loader.sv
// myrisc16_loader: framed byte-stream program loader for the myrisc16 core.
// Frame: SYNC, ADDR_H, ADDR_L, CNT_H, CNT_L, CNT x (DATA_H, DATA_L), CKSUM.
// Writes 16-bit words to memory, holds the core in reset while loading and
// releases it on a GO frame (count 0, good checksum, no sticky error).
// Optional build macro: MYRISC16_LOADER_TIMEOUT_EN enables the inter-byte timeout.
module myrisc16_loader #(
    parameter int unsigned ADDR_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rstn,
    output logic              busy,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_AH,
        S_AL,
        S_CH,
        S_CL,
        S_DH,
        S_DL,
        S_WR,
        S_CK
    } state_t;

    state_t              r_state;
    logic                r_rx_ready;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [15:0]         r_mem_wdata;
    logic                r_cpu_rstn;
    logic                r_busy;
    logic                r_err;

    logic [7:0]          r_addr_h;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_cnt_h;
    logic [15:0]         r_count;
    logic [15:0]         r_remain;
    logic [7:0]          r_data_h;
    logic [7:0]          r_sum;

    logic                w_accept;
    logic [7:0]          w_sum_next;
    logic [15:0]         w_count_in;
    logic                w_timeout;

    assign w_accept   = rx_valid && r_rx_ready;
    assign w_sum_next = r_sum + rx_data;
    assign w_count_in = {r_cnt_h, rx_data};

`ifdef MYRISC16_LOADER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_run;

    assign w_to_run  = (r_state != S_IDLE) && (r_state != S_WR);
    assign w_timeout = w_to_run && !w_accept && (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Idle-cycle counter: cleared by every accepted byte and outside the parsing states
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_to_cnt <= '0;
        end else if (w_accept || !w_to_run || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout        = 1'b0;
`endif

    // Frame parser, memory write strobe and core-reset control
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rstn  <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_addr_h    <= '0;
            r_addr      <= '0;
            r_cnt_h     <= '0;
            r_count     <= '0;
            r_remain    <= '0;
            r_data_h    <= '0;
            r_sum       <= '0;
        end else begin
            r_mem_we   <= 1'b0;
            r_rx_ready <= 1'b1;

            // Every byte after SYNC feeds the checksum
            if (w_accept && (r_state != S_IDLE)) begin
                r_sum <= w_sum_next;
            end

            case (r_state)
                S_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_accept && (rx_data == SYNC_BYTE)) begin
                        r_state    <= S_AH;
                        r_busy     <= 1'b1;
                        r_cpu_rstn <= 1'b0;
                        r_sum      <= '0;
                        r_count    <= '0;
                    end
                end
                S_AH: begin
                    if (w_accept) begin
                        r_addr_h <= rx_data;
                        r_state  <= S_AL;
                    end
                end
                S_AL: begin
                    if (w_accept) begin
                        r_addr  <= ADDR_W'({r_addr_h, rx_data});
                        r_state <= S_CH;
                    end
                end
                S_CH: begin
                    if (w_accept) begin
                        r_cnt_h <= rx_data;
                        r_state <= S_CL;
                    end
                end
                S_CL: begin
                    if (w_accept) begin
                        r_count  <= w_count_in;
                        r_remain <= w_count_in;
                        r_state  <= (w_count_in == 16'd0) ? S_CK : S_DH;
                    end
                end
                S_DH: begin
                    if (w_accept) begin
                        r_data_h <= rx_data;
                        r_state  <= S_DL;
                    end
                end
                S_DL: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= {r_data_h, rx_data};
                        r_rx_ready  <= 1'b0;
                        r_state     <= S_WR;
                    end
                end
                S_WR: begin
                    r_addr   <= r_addr + ADDR_W'(1);
                    r_remain <= r_remain - 16'd1;
                    r_state  <= (r_remain == 16'd1) ? S_CK : S_DH;
                end
                S_CK: begin
                    if (w_accept) begin
                        if (w_sum_next != 8'h00) begin
                            r_err <= 1'b1;
                        end else if ((r_count == 16'd0) && !r_err) begin
                            r_cpu_rstn <= 1'b1;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Stalled link abandons the frame; the core stays held
            if (w_timeout) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
                r_err   <= 1'b1;
            end
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rstn  = r_cpu_rstn;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_myrisc16_loader.sv
// Directed bench for myrisc16_loader: load, GO, bad checksum, wrap, backpressure, timeout.
module tb_myrisc16_loader;

    logic        clk;
    logic        rstn;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_rstn;
    logic        busy;
    logic        err;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 1'b0;

    logic [7:0]  seq[$];
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] exp_a[$];
    logic [15:0] exp_d[$];

    myrisc16_loader #(
        .ADDR_W    (16),
        .SYNC_BYTE (8'hA5),
        .TIMEOUT   (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rstn  (cpu_rstn),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Log every write-strobe cycle; a stretched strobe shows up as an extra entry
    always @(negedge clk) begin
        if (mem_we) begin
            wr_a.push_back(mem_addr);
            wr_d.push_back(mem_wdata);
        end
        if (mon_en) check("ready_vs_we", rx_ready, !mem_we);
    end

    task automatic send_byte(input logic [7:0] b);
        bit done;
        done     = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 64 && !done; i++) begin
            if (rx_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        check("rx_accept", done, 1'b1);
    endtask

    task automatic send_seq();
        foreach (seq[i]) send_byte(seq[i]);
        rx_valid = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, wr_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size() && i < wr_a.size(); i++) begin
            check({tag, "_addr"}, wr_a[i], exp_a[i]);
            check({tag, "_data"}, wr_d[i], exp_d[i]);
        end
        wr_a.delete();
        wr_d.delete();
    endtask

    task automatic do_reset();
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        wr_a.delete();
        wr_d.delete();
        rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        @(posedge clk); #1;
        do_reset();
        rstn = 1'b0;
        @(posedge clk); #1;
        check("rst_ready", rx_ready, 1'b0);
        check("rst_we", mem_we, 1'b0);
        check("rst_addr", mem_addr, 16'h0000);
        check("rst_wdata", mem_wdata, 16'h0000);
        check("rst_cpu", cpu_rstn, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        rstn = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", rx_ready, 1'b1);

        // Test 1: two-word load, strobe one cycle after DATA_L
        seq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
        foreach (seq[i]) send_byte(seq[i]);
        send_byte(8'h34);
        check("t1_we_after_dl", mem_we, 1'b1);
        check("t1_ready_in_wr", rx_ready, 1'b0);
        check("t1_addr0", mem_addr, 16'h0010);
        check("t1_data0", mem_wdata, 16'h1234);
        seq = '{8'h56, 8'h78, 8'hDA};
        send_seq();
        exp_a = '{16'h0010, 16'h0011};
        exp_d = '{16'h1234, 16'h5678};
        check_writes("t1");
        check("t1_err", err, 1'b0);
        check("t1_cpu", cpu_rstn, 1'b0);
        check("t1_busy", busy, 1'b0);

        // Test 2: GO releases the core; a new SYNC grabs it back
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
        foreach (seq[i]) send_byte(seq[i]);
        check("t2_cpu_before_ck", cpu_rstn, 1'b0);
        send_byte(8'h00);
        rx_valid = 1'b0;
        check("t2_go", cpu_rstn, 1'b1);
        check("t2_busy", busy, 1'b0);
        check("t2_err", err, 1'b0);
        send_byte(8'hA5);
        rx_valid = 1'b0;
        check("t2_resync_cpu", cpu_rstn, 1'b0);
        check("t2_resync_busy", busy, 1'b1);
        do_reset();

        // Test 4: address wraps from FFFF to 0000
        seq = '{8'hA5, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'h36};
        send_seq();
        exp_a = '{16'hFFFF, 16'h0000};
        exp_d = '{16'hAAAA, 16'hBBBB};
        check_writes("t4");
        check("t4_err", err, 1'b0);

        // Test 5: leading noise, rx_valid held high through the whole frame
        mon_en = 1'b1;
        send_byte(8'h00);
        send_byte(8'h11);
        check("t5_noise_busy", busy, 1'b0);
        seq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA};
        send_seq();
        @(negedge clk);
        mon_en = 1'b0;
        exp_a = '{16'h0010, 16'h0011};
        exp_d = '{16'h1234, 16'h5678};
        check_writes("t5");
        check("t5_err", err, 1'b0);
        check("t5_busy", busy, 1'b0);

        // Test 3: bad checksum keeps writes, sets sticky err, blocks GO
        seq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDB};
        send_seq();
        check_writes("t3");
        check("t3_err", err, 1'b1);
        check("t3_cpu", cpu_rstn, 1'b0);
        seq = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_seq();
        check("t3_go_blocked", cpu_rstn, 1'b0);
        check("t3_err_sticky", err, 1'b1);
        do_reset();

        // Test 6: link stalls mid-header
        seq = '{8'hA5, 8'h00, 8'h10};
        send_seq();
        repeat (15) @(posedge clk);
        #1;
        check("t6_busy_15", busy, 1'b1);
        check("t6_err_15", err, 1'b0);
        @(posedge clk); #1;
        exp_a.delete();
        exp_d.delete();
        check_writes("t6_none");
`ifdef MYRISC16_LOADER_TIMEOUT_EN
        check("t6_err", err, 1'b1);
        check("t6_busy", busy, 1'b0);
        check("t6_cpu", cpu_rstn, 1'b0);
        seq = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hDA};
        send_seq();
        exp_a = '{16'h0010, 16'h0011};
        exp_d = '{16'h1234, 16'h5678};
        check_writes("t6_reload");
        check("t6_reload_busy", busy, 1'b0);
`else
        check("t6_busy", busy, 1'b1);
        check("t6_err", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
